// File: rtl/mu02_core.sv
// mu02_core: accumulator CPU with a four-state FSM (fetch/exec/mem/halt) on a
// single req/ack memory port. All bus outputs are registered and held until ack.
module mu02_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              run,
    output logic              halted,
    output logic              illegal,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        flags_out
);

    localparam logic [3:0] OpLda  = 4'h0;
    localparam logic [3:0] OpSto  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpJmp  = 4'h4;
    localparam logic [3:0] OpJge  = 4'h5;
    localparam logic [3:0] OpJne  = 4'h6;
    localparam logic [3:0] OpStp  = 4'h7;
    localparam logic [3:0] OpLdai = 4'h8;
    localparam logic [3:0] OpAddi = 4'hA;
    localparam logic [3:0] OpSubi = 4'hB;
    localparam logic [3:0] OpJc   = 4'hC;
    localparam logic [3:0] OpJv   = 4'hD;

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] ir_q;
    logic [3:0]        flags_q;
    logic              illegal_q;
    logic              halted_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] acc_d;
    logic [3:0]        flags_d;
    logic              take;
    logic [ADDR_W-1:0] pc_tgt;

    assign op   = ir_q[DATA_W-1 -: 4];
    assign addr = ir_q[ADDR_W-1:0];
    assign imm  = {{4{ir_q[DATA_W-5]}}, ir_q[DATA_W-5:0]};

    // flags_d is {C,V,N,Z}; loads fall through with C and V cleared
    always_comb begin
        alu_b   = (state_q == StMem) ? mem_rdata : imm;
        sum     = {1'b0, acc_q} + {1'b0, alu_b};
        diff    = {1'b0, acc_q} - {1'b0, alu_b};
        acc_d   = alu_b;
        flags_d = 4'b0000;
        case (op)
            OpAdd, OpAddi: begin
                acc_d      = sum[DATA_W-1:0];
                flags_d[3] = sum[DATA_W];
                flags_d[2] = (acc_q[DATA_W-1] == alu_b[DATA_W-1]) &&
                             (sum[DATA_W-1] != acc_q[DATA_W-1]);
            end
            OpSub, OpSubi: begin
                acc_d      = diff[DATA_W-1:0];
                flags_d[3] = diff[DATA_W];
                flags_d[2] = (acc_q[DATA_W-1] != alu_b[DATA_W-1]) &&
                             (diff[DATA_W-1] != acc_q[DATA_W-1]);
            end
            default: ;
        endcase
        flags_d[1] = acc_d[DATA_W-1];
        flags_d[0] = (acc_d == '0);
    end

    always_comb begin
        take = 1'b0;
        case (op)
            OpJmp:   take = 1'b1;
            OpJge:   take = ~flags_q[1];
            OpJne:   take = ~flags_q[0];
            OpJc:    take = flags_q[3];
            OpJv:    take = flags_q[2];
            default: take = 1'b0;
        endcase
        pc_tgt = take ? addr : pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            acc_q       <= '0;
            ir_q        <= '0;
            flags_q     <= '0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    // Only the first cycle after reset lands here without a request up
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ack) begin
                        ir_q      <= mem_rdata;
                        pc_q      <= pc_q + ADDR_W'(1);
                        mem_req_q <= 1'b0;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    case (op)
                        OpLdai, OpAddi, OpSubi, OpJmp, OpJge, OpJne, OpJc, OpJv: begin
                            if (op == OpLdai || op == OpAddi || op == OpSubi) begin
                                acc_q   <= acc_d;
                                flags_q <= flags_d;
                            end
                            pc_q       <= pc_tgt;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pc_tgt;
                            state_q    <= StFetch;
                        end
                        OpLda, OpAdd, OpSub, OpSto: begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (op == OpSto);
                            mem_addr_q  <= addr;
                            mem_wdata_q <= acc_q;
                            state_q     <= StMem;
                        end
                        OpStp: begin
                            halted_q <= 1'b1;
                            state_q  <= StHalt;
                        end
                        default: begin
                            halted_q  <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= StHalt;
                        end
                    endcase
                end
                StMem: begin
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            acc_q   <= acc_d;
                            flags_q <= flags_d;
                        end
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                        state_q    <= StFetch;
                    end
                end
                StHalt: begin
                    if (run) begin
                        halted_q   <= 1'b0;
                        illegal_q  <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                        state_q    <= StFetch;
                    end
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign acc_out   = acc_q;
    assign pc_out    = pc_q;
    assign flags_out = flags_q;

endmodule

// File: doc/mu02_core.md
MU02_CORE -- requirements
Module: mu02_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: accumulator, data and instruction word width; legal range 8..32.
REQ-002 The block SHALL have parameter ADDR_W, default 12: PC and memory address width; ADDR_W <= DATA_W-4.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (core held in reset while reset=0).
REQ-005 The block SHALL have port mem_req, output, 1 bit: memory transaction request.
REQ-006 The block SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read; valid while mem_req=1.
REQ-007 The block SHALL have port mem_addr, output, ADDR_W bits: transaction address.
REQ-008 The block SHALL have port mem_wdata, output, DATA_W bits: write data.
REQ-009 The block SHALL have port mem_rdata, input, DATA_W bits: read data, sampled in the cycle mem_ack=1.
REQ-010 The block SHALL have port mem_ack, input, 1 bit: transaction completes in any cycle where mem_req=1 and mem_ack=1.
REQ-011 The block SHALL have port run, input, 1 bit: resumes execution from HALT.
REQ-012 The block SHALL have ports halted and illegal, outputs, 1 bit each: core in HALT; HALT was entered by an undefined opcode.
REQ-013 The block SHALL have ports acc_out (DATA_W), pc_out (ADDR_W) and flags_out (4 bits, {C,V,N,Z}), outputs: architectural state.

Function
REQ-014 Instruction format SHALL be opcode = ir[DATA_W-1:DATA_W-4] and operand = ir[DATA_W-5:0]; address = operand[ADDR_W-1:0]; immediate = operand sign-extended to DATA_W.
REQ-015 Opcodes SHALL be: 0000 LDA, 0001 STO, 0010 ADD, 0011 SUB, 0100 JMP, 0101 JGE, 0110 JNE, 0111 STP, 1000 LDAI, 1010 ADDI, 1011 SUBI, 1100 JC, 1101 JV; all others undefined.
REQ-016 The FSM SHALL have states FETCH, EXEC, MEM and HALT.
REQ-017 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc; on ack it loads ir, sets pc=pc+1 mod 2^ADDR_W and moves to EXEC.
REQ-018 EXEC SHALL complete LDAI/ADDI/SUBI/jumps in one cycle and return to FETCH; LDA/ADD/SUB/STO SHALL go to MEM; STP SHALL go to HALT; undefined opcodes SHALL go to HALT with illegal=1.
REQ-019 MEM SHALL drive mem_req=1, mem_addr=address; STO SHALL drive mem_we=1 and mem_wdata=acc; on ack the result is written and the FSM returns to FETCH.
REQ-020 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable until ack; ack with mem_req=0 SHALL be ignored; zero-wait (same-cycle) ack SHALL be legal.
REQ-021 Latency with zero-wait memory SHALL be 2 cycles for register/jump ops and 3 cycles for memory ops; each wait cycle adds 1.
REQ-022 ADD/ADDI SHALL compute a (DATA_W+1)-bit sum: C = carry-out, V = signed overflow (operands same sign, result differs).
REQ-023 SUB/SUBI SHALL compute acc - b: C = borrow (acc < b unsigned), V = signed overflow (operands differ in sign, result sign differs from acc).
REQ-024 Every acc write SHALL update Z (acc==0) and N (acc[DATA_W-1]); LDA/LDAI SHALL clear C and V; STO and jumps SHALL leave flags unchanged.
REQ-025 Jumps SHALL set pc=address: JMP always; JGE if N=0 (signed >= 0); JNE if Z=0; JC if C=1; JV if V=1.
REQ-026 In HALT, mem_req SHALL be 0 and halted SHALL be 1; run=1 SHALL move to FETCH at the current pc and clear illegal; run is ignored outside HALT.
REQ-027 pc wrap-around SHALL be silent; fetch at address 2^ADDR_W-1 SHALL be followed by fetch at 0.

Reset
REQ-028 While reset=0, all of the following SHALL be forced, asynchronously: state=FETCH, pc=0, acc=0, ir=0, flags=0, illegal=0, halted=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset asserted mid-transaction SHALL drop mem_req immediately; after release, the first fetch SHALL be from address 0.

Verification
REQ-030 Test: LDAI 0x7FF; ADDI 1; STO 0xFFF; STP, zero-wait -> mem[0xFFF]=0x0800, flags C=0 V=0 N=0 Z=0, halted=1 after 10 cycles.
REQ-031 Test: mem[0x100]=0x7FFF; LDA 0x100; ADDI 1 -> acc=0x8000, V=1, N=1, C=0; JV 0x010 is taken.
REQ-032 Test: LDAI 0; SUBI 1 -> acc=0xFFFF, C=1, N=1, V=0; JGE is not taken; JNE is taken.
REQ-033 Test: memory acks after 3 wait cycles -> request signals stay stable; LDA completes in 9 cycles; extra acks while mem_req=0 are ignored.
REQ-034 Test: opcode 1111 -> halted=1, illegal=1; run pulse -> fetch from pc+1 and illegal=0; reset=0 during a MEM wait -> mem_req=0 in the same cycle, pc=0.
REQ-035 Test: DATA_W=8, ADDR_W=4: JMP 0xF; the instruction at 0xF is a non-jump -> the next fetch address is 0x0.
